// File: rtl/poly_tone_gen_if.sv
// Note-update port for poly_tone_gen.
// Sequencer drives the request, generator returns ready.
interface poly_tone_gen_if #(
    parameter int NCH   = 4,
    parameter int DIV_W = 22
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic             upd_valid;
    logic             upd_ready;
    logic [CH_W-1:0]  upd_ch;
    logic [DIV_W-1:0] upd_div;
    logic [14:0]      upd_vol;
    logic             upd_gate;
    logic [1:0]       upd_pan;

    modport master (
        output upd_valid, upd_ch, upd_div,
        output upd_vol, upd_gate, upd_pan,
        input  upd_ready
    );

    modport slave (
        input  upd_valid, upd_ch, upd_div,
        input  upd_vol, upd_gate, upd_pan,
        output upd_ready
    );
endinterface

// File: rtl/poly_tone_gen.sv
// Multi-channel square-wave tone generator with
// volume envelope, stereo pan and saturating mixer.
module poly_tone_gen #(
    parameter int NCH       = 4,
    parameter int DIV_W     = 22,
    parameter int RAMP_DIV  = 1000,
    parameter int RAMP_STEP = 512
) (
    input  logic               clk,
    input  logic               rst_n,
    poly_tone_gen_if.slave     upd,
    output logic signed [15:0] audio_left,
    output logic signed [15:0] audio_right,
    output logic [NCH-1:0]     active
);
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int ACC_W = 17 + $clog2(NCH);

    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-32768);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick;

    logic [DIV_W-1:0] cnt_q [NCH];
    logic [DIV_W-1:0] cnt_d [NCH];
    logic [DIV_W-1:0] div_q [NCH];
    logic [DIV_W-1:0] div_d [NCH];
    logic [DIV_W-1:0] pdiv_q [NCH];
    logic [DIV_W-1:0] pdiv_d [NCH];
    logic [14:0]      amp_q [NCH];
    logic [14:0]      amp_d [NCH];
    logic [14:0]      vol_q [NCH];
    logic [14:0]      vol_d [NCH];
    logic [14:0]      pvol_q [NCH];
    logic [14:0]      pvol_d [NCH];
    logic [1:0]       pan_q [NCH];
    logic [1:0]       pan_d [NCH];
    logic [1:0]       ppan_q [NCH];
    logic [1:0]       ppan_d [NCH];

    logic [NCH-1:0] phase_q, phase_d;
    logic [NCH-1:0] gate_q, gate_d;
    logic [NCH-1:0] pgate_q, pgate_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] tog, idle;

    logic signed [15:0] left_q, left_d;
    logic signed [15:0] right_q, right_d;
    logic [NCH-1:0]     active_q, active_d;

    logic [CH_W-1:0] ch_sel;

    assign ch_sel        = (NCH == 1) ? '0 : upd.upd_ch;
    assign upd.upd_ready = ~pend_q[ch_sel];
    assign audio_left    = left_q;
    assign audio_right   = right_q;
    assign active        = active_q;

    // One envelope step toward the target, clamped without wrapping.
    function automatic logic [14:0] env_next(
        input logic [14:0] amp,
        input logic [14:0] vol,
        input logic        gate
    );
        logic [15:0] a, v, s, up;
        logic [14:0] r;
        a  = {1'b0, amp};
        v  = {1'b0, vol};
        s  = 16'(RAMP_STEP);
        up = a + s;
        r  = amp;
        if (gate) begin
            if (a < v) begin
                r = (up > v) ? vol : up[14:0];
            end else if (a > v) begin
                r = ((a - v) > s) ? 15'(a - s) : vol;
            end
        end else begin
            r = (a > s) ? 15'(a - s) : 15'd0;
        end
        return r;
    endfunction

    function automatic logic signed [15:0] sat16(
        input logic signed [ACC_W-1:0] x
    );
        logic signed [15:0] r;
        if (x > MAXV) begin
            r = 16'sh7fff;
        end else if (x < MINV) begin
            r = 16'sh8000;
        end else begin
            r = x[15:0];
        end
        return r;
    endfunction

    // Shared envelope prescaler.
    always_comb begin
        tick  = (pre_q == PRE_W'(RAMP_DIV - 1));
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    // Per-channel toggle event and idle detection.
    always_comb begin
        tog  = '0;
        idle = '0;
        for (int i = 0; i < NCH; i++) begin
            tog[i]  = (div_q[i] != '0) && (cnt_q[i] == div_q[i]);
            idle[i] = ((amp_q[i] == '0) && !gate_q[i]) ||
                      (div_q[i] == '0);
        end
    end

    // Channel next state: tone counter, apply, accept, envelope.
    always_comb begin
        phase_d = phase_q;
        gate_d  = gate_q;
        pgate_d = pgate_q;
        pend_d  = pend_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i]  = cnt_q[i];
            div_d[i]  = div_q[i];
            pdiv_d[i] = pdiv_q[i];
            amp_d[i]  = amp_q[i];
            vol_d[i]  = vol_q[i];
            pvol_d[i] = pvol_q[i];
            pan_d[i]  = pan_q[i];
            ppan_d[i] = ppan_q[i];

            if (div_q[i] != '0) begin
                if (tog[i]) begin
                    cnt_d[i]   = '0;
                    phase_d[i] = ~phase_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end

            // Idle channels restart from phase 0 immediately;
            // sounding channels switch only on a half-period edge.
            if (pend_q[i] && (idle[i] || tog[i])) begin
                div_d[i]  = pdiv_q[i];
                vol_d[i]  = pvol_q[i];
                gate_d[i] = pgate_q[i];
                pan_d[i]  = ppan_q[i];
                pend_d[i] = 1'b0;
                if (idle[i]) begin
                    cnt_d[i]   = '0;
                    phase_d[i] = 1'b0;
                end
            end

            if (upd.upd_valid && !pend_q[i] &&
                (ch_sel == CH_W'(i))) begin
                pend_d[i]  = 1'b1;
                pdiv_d[i]  = upd.upd_div;
                pvol_d[i]  = upd.upd_vol;
                pgate_d[i] = upd.upd_gate;
                ppan_d[i]  = upd.upd_pan;
            end

            if (tick) begin
                amp_d[i] = env_next(amp_q[i], vol_q[i], gate_q[i]);
            end
        end
    end

    // Stereo mix with saturation; outputs registered.
    always_comb begin
        logic signed [ACC_W-1:0] sum_l, sum_r;
        logic signed [16:0]      smp;
        sum_l    = '0;
        sum_r    = '0;
        smp      = '0;
        active_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (div_q[i] == '0) begin
                smp = '0;
            end else if (phase_q[i]) begin
                smp = $signed({2'b00, amp_q[i]});
            end else begin
                smp = -$signed({2'b00, amp_q[i]});
            end
            if (pan_q[i][0]) sum_l = sum_l + ACC_W'(smp);
            if (pan_q[i][1]) sum_r = sum_r + ACC_W'(smp);
            active_d[i] = (amp_q[i] != '0);
        end
        left_d  = sat16(sum_l);
        right_d = sat16(sum_r);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            phase_q  <= '0;
            gate_q   <= '0;
            pgate_q  <= '0;
            pend_q   <= '0;
            left_q   <= '0;
            right_q  <= '0;
            active_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]  <= '0;
                div_q[i]  <= '0;
                pdiv_q[i] <= '0;
                amp_q[i]  <= '0;
                vol_q[i]  <= '0;
                pvol_q[i] <= '0;
                pan_q[i]  <= '0;
                ppan_q[i] <= '0;
            end
        end else begin
            pre_q    <= pre_d;
            phase_q  <= phase_d;
            gate_q   <= gate_d;
            pgate_q  <= pgate_d;
            pend_q   <= pend_d;
            left_q   <= left_d;
            right_q  <= right_d;
            active_q <= active_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                div_q[i]  <= div_d[i];
                pdiv_q[i] <= pdiv_d[i];
                amp_q[i]  <= amp_d[i];
                vol_q[i]  <= vol_d[i];
                pvol_q[i] <= pvol_d[i];
                pan_q[i]  <= pan_d[i];
                ppan_q[i] <= ppan_d[i];
            end
        end
    end
endmodule

// File: tb/tb_poly_tone_gen.sv
// Bench for poly_tone_gen: directed table, corner
// sequences and random updates against a cycle model.
module tb_poly_tone_gen;
    localparam int NCH   = 4;
    localparam int DIV_W = 22;
    localparam int RDIV  = 4;
    localparam int RSTEP = 250;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] audio_left, audio_right;
    logic [NCH-1:0]     active;

    poly_tone_gen_if #(.NCH(NCH), .DIV_W(DIV_W)) ifc ();

    poly_tone_gen #(
        .NCH(NCH), .DIV_W(DIV_W),
        .RAMP_DIV(RDIV), .RAMP_STEP(RSTEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .upd(ifc),
        .audio_left(audio_left), .audio_right(audio_right),
        .active(active)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm,
                       input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: time-based toggles, queued pending updates.
    typedef struct {
        int dv;
        int vol;
        bit gate;
        int pan;
    } upd_t;

    upd_t   m_pq [NCH][$];
    int     m_amp [NCH], m_vol [NCH], m_div [NCH], m_pan [NCH];
    bit     m_gate [NCH], m_phase [NCH];
    longint m_next [NCH];
    longint m_k;
    int     m_l, m_r;
    bit [NCH-1:0] m_act;
    bit     m_acc;

    function automatic int env(input int a, input int v, input bit g);
        if (g) begin
            if (a < v) return (a + RSTEP < v) ? a + RSTEP : v;
            if (a > v) return (a - RSTEP > v) ? a - RSTEP : v;
            return a;
        end
        return (a - RSTEP > 0) ? a - RSTEP : 0;
    endfunction

    function automatic int sat(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int sl, sr, s, na;
        bit tick, acc, tg, idl;
        upd_t u;
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_pq[c].delete();
                m_amp[c] = 0; m_vol[c] = 0; m_div[c] = 0;
                m_pan[c] = 0; m_gate[c] = 0; m_phase[c] = 0;
                m_next[c] = 0;
            end
            m_k = 0; m_l = 0; m_r = 0; m_act = '0; m_acc = 0;
        end else begin
            sl = 0; sr = 0;
            for (int c = 0; c < NCH; c++) begin
                s = (m_div[c] == 0) ? 0 :
                    (m_phase[c] ? m_amp[c] : -m_amp[c]);
                if (m_pan[c] % 2 == 1) sl += s;
                if (m_pan[c] >= 2) sr += s;
                m_act[c] = (m_amp[c] != 0);
            end
            m_l = sat(sl);
            m_r = sat(sr);
            tick = ((m_k % RDIV) == RDIV - 1);
            acc = ifc.upd_valid && (m_pq[ifc.upd_ch].size() == 0);
            for (int c = 0; c < NCH; c++) begin
                tg  = (m_div[c] != 0) && (m_k == m_next[c]);
                idl = (m_amp[c] == 0 && !m_gate[c]) || m_div[c] == 0;
                na  = tick ? env(m_amp[c], m_vol[c], m_gate[c])
                           : m_amp[c];
                if (m_pq[c].size() != 0 && idl) begin
                    u = m_pq[c].pop_front();
                    m_div[c] = u.dv; m_vol[c] = u.vol;
                    m_gate[c] = u.gate; m_pan[c] = u.pan;
                    m_phase[c] = 0;
                    m_next[c] = m_k + 1 + u.dv;
                end else if (tg) begin
                    m_phase[c] = !m_phase[c];
                    if (m_pq[c].size() != 0) begin
                        u = m_pq[c].pop_front();
                        m_div[c] = u.dv; m_vol[c] = u.vol;
                        m_gate[c] = u.gate; m_pan[c] = u.pan;
                    end
                    m_next[c] = m_k + 1 + m_div[c];
                end
                m_amp[c] = na;
            end
            if (acc) begin
                u.dv = int'(ifc.upd_div); u.vol = int'(ifc.upd_vol);
                u.gate = ifc.upd_gate; u.pan = int'(ifc.upd_pan);
                m_pq[ifc.upd_ch].push_back(u);
            end
            m_acc = acc;
            m_k++;
        end
    end

    // Scoreboard: every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("sb_left", audio_left, m_l);
        chk("sb_right", audio_right, m_r);
        chk("sb_active", active, m_act);
        chk("sb_ready", ifc.upd_ready,
            (m_pq[ifc.upd_ch].size() == 0) ? 1 : 0);
    end

    task automatic drive(input int ch, input int dv, input int vol,
                         input bit g, input int pan);
        ifc.upd_ch    = 2'(ch);
        ifc.upd_div   = DIV_W'(dv);
        ifc.upd_vol   = 15'(vol);
        ifc.upd_gate  = g;
        ifc.upd_pan   = 2'(pan);
        ifc.upd_valid = 1'b1;
    endtask

    task automatic wait_acc(output int cyc);
        cyc = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (m_acc) return;
        end
        chk("accept_timeout", 0, 1);
    endtask

    task automatic send(input int ch, input int dv, input int vol,
                        input bit g, input int pan);
        int cyc;
        @(posedge clk); #1;
        drive(ch, dv, vol, g, pan);
        wait_acc(cyc);
        ifc.upd_valid = 1'b0;
    endtask

    task automatic measure_half(output int n);
        logic s0;
        int   k;
        n = 0;
        @(negedge clk);
        s0 = audio_left[15];
        k = 0;
        while (audio_left[15] == s0 && k < 400) begin
            @(negedge clk); k++;
        end
        s0 = audio_left[15];
        while (k < 400) begin
            @(negedge clk); k++; n++;
            if (audio_left[15] != s0) return;
        end
        chk("measure_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    typedef struct {
        int ch;
        int dv;
        int vol;
        bit gate;
        int pan;
        int wt;
        bit [NCH-1:0] act;
        int al;
        int ar;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int n, cyc, mx, mn;
        tbl[0] = '{0, 3, 1000, 1, 1, 40, 4'b0001, 1000, 0};
        tbl[1] = '{1, 5, 500, 1, 2, 40, 4'b0011, 1000, 500};
        tbl[2] = '{0, 0, 1000, 1, 1, 40, 4'b0011, 0, 500};
        tbl[3] = '{1, 5, 500, 0, 2, 40, 4'b0001, 0, 0};
        tbl[4] = '{0, 0, 0, 0, 1, 40, 4'b0000, 0, 0};
        tbl[5] = '{2, 7, 32767, 1, 3, 600, 4'b0100, 32767, 32767};

        ifc.upd_valid = 1'b0;
        ifc.upd_ch    = '0;
        ifc.upd_div   = '0;
        ifc.upd_vol   = '0;
        ifc.upd_gate  = 1'b0;
        ifc.upd_pan   = '0;
        #2;
        chk("rst_left", audio_left, 0);
        chk("rst_right", audio_right, 0);
        chk("rst_active", active, 0);
        chk("rst_ready", ifc.upd_ready, 1);
        #21 rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            send(tbl[i].ch, tbl[i].dv, tbl[i].vol,
                 tbl[i].gate, tbl[i].pan);
            repeat (tbl[i].wt) @(posedge clk);
            @(negedge clk);
            chk("tbl_active", active, tbl[i].act);
            chk("tbl_abs_left", iabs(int'(audio_left)), tbl[i].al);
            chk("tbl_abs_right", iabs(int'(audio_right)), tbl[i].ar);
        end

        // Four full-scale channels on one pan: mixer must clamp.
        do_reset();
        for (int c = 0; c < NCH; c++) send(c, 7, 32767, 1, 3);
        repeat (600) @(posedge clk);
        mx = -100000; mn = 100000;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (int'(audio_left) > mx) mx = int'(audio_left);
            if (int'(audio_left) < mn) mn = int'(audio_left);
        end
        chk("sat_max", mx, 32767);
        chk("sat_min", mn, -32768);

        // Divider change on a sounding channel waits for the edge.
        do_reset();
        send(2, 99, 1000, 1, 1);
        repeat (40) @(posedge clk);
        measure_half(n);
        chk("half_div99", n, 100);
        repeat (30) @(posedge clk);
        send(2, 9, 1000, 1, 1);
        drive(2, 9, 800, 1, 1);
        #1;
        chk("ready_while_pending", ifc.upd_ready, 0);
        wait_acc(cyc);
        ifc.upd_valid = 1'b0;
        chk("held_until_apply", (cyc > 20) ? 1 : 0, 1);
        measure_half(n);
        chk("half_div9", n, 10);

        // Reset with an update still pending.
        send(2, 50, 2000, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_left", audio_left, 0);
        chk("mid_rst_right", audio_right, 0);
        chk("mid_rst_active", active, 0);
        chk("mid_rst_ready", ifc.upd_ready, 1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("no_stale_apply", active, 0);

        // Random updates, checked cycle by cycle by the model.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            send($urandom % NCH,
                 ($urandom % 4 == 0) ? 0 : $urandom_range(1, 20),
                 $urandom % 32768,
                 ($urandom % 4) != 0,
                 $urandom % 4);
            repeat ($urandom_range(0, 30)) @(posedge clk);
        end
        repeat (50) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/poly_tone_gen.md
Name: poly_tone_gen

Overview:
Multi-channel square-wave tone generator with per-channel volume envelope, stereo pan and saturating mixer. It is the parametrised successor to the single-note buzzer driver. It sits between the keyboard/note sequencer and the audio DAC serializer. Note updates arrive over a valid/ready port, and are applied glitch-free at the channel's next half-period boundary.

Parameters:
NCH, 4, number of tone channels (power of two, 1..16)
DIV_W, 22, width of half-period divider
RAMP_DIV, 1000, clk cycles per envelope tick (>=1)
RAMP_STEP, 512, amplitude change per envelope tick (1..32767)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
upd_valid  in  1  note update request
upd_ready  out  1  update accepted when valid&ready
upd_ch  in  log2(NCH) (min 1)  target channel
upd_div  in  DIV_W  half-period divider; 0 = silent channel
upd_vol  in  15  target amplitude magnitude
upd_gate  in  1  1 = note on (ramp up), 0 = note off (ramp down)
upd_pan  in  2  bit0 = route to left, bit1 = route to right
audio_left  out  16  signed mixed left sample
audio_right  out  16  signed mixed right sample
active  out  NCH  bit i = channel i amplitude nonzero

Behaviour:
- Reset (async, rst_n=0): all counters, phases, amplitudes, settings and pending flags are 0; audio_left/right=0; active=0; upd_ready=1.
- Per-channel state: cnt[DIV_W], phase, amp[15], div, vol, gate, pan, pending entry (div, vol, gate, pan).
- Tone: if div!=0, cnt increments each clk; when cnt==div, cnt<=0 and phase toggles ("toggle event"). Period = 2*(div+1) clk. If div==0, cnt and phase are held at 0.
- upd_ready = ~pending_flag[upd_ch] (combinational). An accepted update is stored in the channel's pending entry.
- Apply: the pending entry is copied into the active settings on the channel's next toggle event. If the channel is idle (amp==0 and gate==0) or div==0, it is applied on the cycle after accept, with cnt<=0 and phase<=0. Applying clears the pending flag.
- A pending entry is applied on the same cycle that a new request targets that channel: ready is still low, so the request is not accepted; it is accepted a cycle later. No update is ever dropped or overwritten.
- Envelope: a shared prescaler counts 0..RAMP_DIV-1, and tick is asserted at RAMP_DIV-1. On each tick, per channel:
  - gate=1, amp<vol: amp<=min(amp+RAMP_STEP, vol).
  - gate=1, amp>vol: amp<=max(amp-RAMP_STEP, vol).
  - gate=0: amp<=max(amp-RAMP_STEP, 0).
  - The arithmetic is 16-bit, with no wrap.
- Channel sample s_i = phase ? +amp : -amp (17-bit signed). A channel with div==0 contributes 0.
- Mix: left sum = sum of s_i with pan[0]=1; right uses pan[1]. Accumulate in 17+log2(NCH) bits. Saturate to [-32768, 32767].
- audio_left/right and active are registered: 1 clk latency from channel state to outputs.
- Reset mid-note: outputs go to 0 immediately (async); pending updates are discarded.

Test Plan:
1. NCH=4, RAMP_DIV=1, RAMP_STEP=32767; update ch0 div=3, vol=1000, gate=1, pan=3 → audio_left=audio_right alternating +1000/-1000 every 4 clk (period 8); active=0001.
2. RAMP_DIV=4, RAMP_STEP=250, ch1 vol=1000, gate=1, then gate=0 → amplitude 250, 500, 750, 1000 at 4-clk ticks, then 750…0; active[1] drops 1 clk after amp reaches 0.
3. All 4 channels at vol=32767, same div, in phase, pan=3 → outputs saturate at +32767/-32768, with no wrap.
4. ch2 running div=99; update div=9 mid half-period → old period holds until the next toggle, then 20-clk period; a second request while pending sees upd_ready=0 and is accepted only after apply.
5. ch0 pan=1, ch1 pan=2, each vol=500 → left carries only ch0, right only ch1; div=0 update → that side reads 0.
6. Assert rst_n low mid-tone → outputs, active=0 immediately; after release, upd_ready=1 and no stale pending update is applied.
